// File: rtl/uart_pkg.sv
// Definitions shared by the UART receive and transmit sides:
// the capture FSM state encodings and the default byte width.
package uart_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    localparam logic [1:0] sIdle = 2'b00;
    localparam logic [1:0] sAck  = 2'b01;
    localparam logic [1:0] sWait = 2'b10;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: synchronous write, asynchronous read, no reset on the array.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Captures bytes from uart_receive through its ready/reset_ready handshake and
// buffers them in a first-word-fall-through FIFO with a sticky overflow flag.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_ready,
    output logic                  rx_reset_ready,
    output logic [DATA_WIDTH-1:0] dout,
    input  logic                  pop,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  clear_overflow
);

    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [1:0]            state;
    logic [1:0]            next_state;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  push;
    logic                  do_pop;
    logic                  wr_en;
    logic                  drop;

    always_comb begin
        next_state = state;
        case (state)
            sIdle:   if (rx_ready) next_state = sAck;
            sAck:    next_state = sWait;
            sWait:   if (!rx_ready) next_state = sIdle;
            default: next_state = sIdle;
        endcase
    end

    assign empty  = (count == '0);
    assign full   = (count == FULL_COUNT);
    assign push   = (state == sIdle) && rx_ready;
    assign do_pop = pop && !empty;
    // A full FIFO still accepts the byte when the head leaves on the same edge.
    assign wr_en  = push && (!full || do_pop);
    assign drop   = push && full && !pop;

    // The acknowledge is registered from next_state so it equals state==sAck without decode glitches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= sIdle;
            rx_reset_ready <= 1'b0;
        end else begin
            state          <= next_state;
            rx_reset_ready <= (next_state == sAck);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) overflow <= 1'b1;
            else if (clear_overflow) overflow <= 1'b0;
        end
    end

    fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_mem (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_addr(wr_ptr),
        .wr_data(rx_data),
        .rd_addr(rd_ptr),
        .rd_data(rd_data)
    );

    assign dout = empty ? '0 : rd_data;

endmodule
